// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: instruction field positions,
// opcode encodings and the RUN/HALT state type.
package fetch_sequencer_pkg;

  localparam int INSTR_WIDTH = 28;
  localparam int OPCODE_MSB  = 27;
  localparam int OPCODE_LSB  = 24;
  localparam int TARGET_MSB  = 23;
  localparam int TARGET_LSB  = 16;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_STO     = 4'h1;
  localparam logic [3:0] OP_ADD     = 4'h2;
  localparam logic [3:0] OP_SUB     = 4'h3;
  localparam logic [3:0] OP_BLE     = 4'h4;
  localparam logic [3:0] OP_JMP     = 4'h5;
  localparam logic [3:0] OP_CALL    = 4'h6;
  localparam logic [3:0] OP_RET     = 4'h7;
  localparam logic [3:0] OP_LED     = 4'h8;
  localparam logic [3:0] OP_WVM     = 4'h9;
  localparam logic [3:0] OP_CHCOLOR = 4'hA;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Builds an instruction word; the low 16 bits belong to the datapath.
  function automatic logic [INSTR_WIDTH-1:0] make_instr(input logic [3:0] op,
                                                       input logic [7:0] tgt);
    return {op, tgt, 16'h0000};
  endfunction

endpackage

// File: rtl/return_stack.sv
// Hardware return-address LIFO: synchronous push, combinational top-of-stack,
// no wrap; full/empty guard the pointer.
module return_stack #(
  parameter  int ADDR_WIDTH  = 16,
  parameter  int STACK_DEPTH = 8,
  localparam int PW          = $clog2(STACK_DEPTH),
  localparam int DW          = PW + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  input  logic [ADDR_WIDTH-1:0] iData,
  output logic [ADDR_WIDTH-1:0] oTop,
  output logic [DW-1:0]         oDepth,
  output logic                  oFull,
  output logic                  oEmpty
);

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [DW-1:0]         ptr;

  assign oFull  = (ptr == DW'(STACK_DEPTH));
  assign oEmpty = (ptr == '0);
  assign oDepth = ptr;
  assign oTop   = mem[PW'(ptr - 1'b1)];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of block evaluation order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr <= '0;
    end else if (iPush && !oFull) begin
      ptr <= ptr + 1'b1;
    end else if (iPop && !oEmpty) begin
      ptr <= ptr - 1'b1;
    end
  end

  // NOTE: the storage array has no reset; only the pointer defines which
  // entries are valid, and leaving it out lets the array map to plain RAM.
  always_ff @(posedge Clock) begin
    if (iPush && !oFull) begin
      mem[ptr[PW-1:0]] <= iData;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and call/return sequencer: selects the next ROM address
// each enabled cycle and halts permanently on stack overflow or underflow.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH   = 16,
  parameter int TARGET_WIDTH = 8,
  parameter int STACK_DEPTH  = 8
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         iEnable,
  input  logic [INSTR_WIDTH-1:0]       iInstruction,
  input  logic                         iBranchTaken,
  output logic [ADDR_WIDTH-1:0]        oAddress,
  output logic [$clog2(STACK_DEPTH):0] oDepth,
  output logic                         oOverflow,
  output logic                         oUnderflow,
  output logic                         oHalted
);

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   pc, next_pc, pc_inc, target_ext, stack_top;
  logic [3:0]              opcode;
  logic [TARGET_WIDTH-1:0] target;
  logic                    push, pop, set_ovf, set_unf;
  logic                    full, empty;
  logic                    overflow, underflow;
  logic                    unused_fields;

  assign opcode        = iInstruction[OPCODE_MSB:OPCODE_LSB];
  assign target        = iInstruction[TARGET_LSB +: TARGET_WIDTH];
  assign target_ext    = ADDR_WIDTH'(target);
  assign pc_inc        = pc + 1'b1;
  assign unused_fields = ^iInstruction[TARGET_LSB-1:0];

  return_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .Clock (Clock),
    .Reset (Reset),
    .iPush (push),
    .iPop  (pop),
    .iData (pc_inc),
    .oTop  (stack_top),
    .oDepth(oDepth),
    .oFull (full),
    .oEmpty(empty)
  );

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (iEnable && state == ST_RUN) begin
      case (opcode)
        OP_JMP: next_pc = target_ext;
        OP_CALL: begin
          if (full) begin
            set_ovf    = 1'b1;
            next_state = ST_HALT;
          end else begin
            push    = 1'b1;
            next_pc = target_ext;
          end
        end
        OP_RET: begin
          if (empty) begin
            set_unf    = 1'b1;
            next_state = ST_HALT;
          end else begin
            pop     = 1'b1;
            next_pc = stack_top;
          end
        end
        OP_BLE:  next_pc = iBranchTaken ? target_ext : pc_inc;
        default: next_pc = pc_inc;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_RUN;
      pc        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= next_pc;
      overflow  <= overflow | set_ovf;
      underflow <= underflow | set_unf;
    end
  end

  assign oAddress   = pc;
  assign oOverflow  = overflow;
  assign oUnderflow = underflow;
  assign oHalted    = (state == ST_HALT);

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and call/return sequencer that drives the instruction ROM address bus and consumes the 28-bit instruction word it returns.
- Computes the next fetch address every cycle: sequential, JMP, CALL, RET, or conditional BLE.
- Holds the hardware return-address stack.
- Sits between the instruction ROM and the decode/ALU stage, which supplies the BLE comparison result and the global enable.

Parameters:
- ADDR_WIDTH, 16, width of the ROM address and of the return stack entries.
- TARGET_WIDTH, 8, width of the branch target field in bits [23:16]; zero-extended to ADDR_WIDTH.
- STACK_DEPTH, 8, number of return-address entries; power of two, at least 2.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- iEnable  in  1  1 = advance this cycle; 0 = hold all state.
- iInstruction  in  28  current ROM word: opcode [27:24], target [23:16], rest ignored here.
- iBranchTaken  in  1  from decode/ALU: BLE condition (A <= B) for the current word; valid same cycle.
- oAddress  out  ADDR_WIDTH  ROM address (current PC), registered.
- oDepth  out  log2(STACK_DEPTH)+1  number of valid stack entries.
- oOverflow  out  1  sticky: CALL attempted with stack full.
- oUnderflow  out  1  sticky: RET attempted with stack empty.
- oHalted  out  1  1 while in HALT state.

Behaviour:
- Reset asserted (asynchronous, low):
  - oAddress=0, oDepth=0, oOverflow=0, oUnderflow=0, oHalted=0, state=RUN.
  - Stack contents are don't-care.
- Single-cycle fetch: ROM is combinational, so the next PC is a function of the current oAddress, iInstruction and iBranchTaken in the same cycle. It is registered on the clock edge, giving one instruction per enabled cycle.
- States:
  - RUN: normal sequencing.
  - HALT: oAddress, stack and flags frozen. Exit only by reset.
- RUN, iEnable=1, decoded on the opcode macros:
  - JMP: PC <= zext(target).
  - CALL, stack not full: push PC+1, PC <= zext(target), depth+1.
  - CALL, stack full (depth==STACK_DEPTH): no push, oOverflow <= 1, PC holds, state <= HALT.
  - RET, depth>0: PC <= top entry, pop, depth-1.
  - RET, depth==0: oUnderflow <= 1, PC holds, state <= HALT.
  - BLE, iBranchTaken=1: PC <= zext(target). BLE, iBranchTaken=0: PC+1.
  - All other opcodes (NOP, STO, ADD, SUB, LED, WVM, CHCOLOR, undefined): PC <= PC+1.
- Arithmetic:
  - PC+1 wraps modulo 2^ADDR_WIDTH (FFFF -> 0000).
  - The pushed return address uses the same wrap.
- iEnable=0: nothing changes in either state, including flags. iBranchTaken is ignored.
- Push and pop never occur in the same cycle, since one opcode is active per cycle.
- Reset mid-CALL/RET: the asynchronous reset wins and the partial stack update is discarded.
- oDepth equals the stack pointer. The stack is a LIFO with no wrap; the full and empty checks above are the only guards.

Decomposition:
- Opcode macros (NOP, STO, ADD, SUB, BLE, JMP, CALL, RET, LED, WVM, CHCOLOR) stay in the shared definitions file, along with the field-position constants OPCODE_MSB/LSB and TARGET_MSB/LSB.
- One sub-module: return_stack.
  - Ports: Clock, Reset, iPush, iPop, iData, oTop, oDepth, oFull, oEmpty.
  - Synchronous write, combinational top-of-stack read.
- fetch_sequencer holds the PC register, the RUN/HALT state and the next-PC mux.

Test Plan:
- Reset then iEnable=1 with NOP words: oAddress steps 0,1,2,3,4; hold iEnable=0 for 3 cycles and oAddress stays 4.
- At PC=5, CALL with target 32 (8'd32): next oAddress=32, oDepth=1. Then RET at 35: oAddress=6, oDepth=0.
- At PC=34, BLE target 32 with iBranchTaken=1: next oAddress=32. Repeat with iBranchTaken=0: next oAddress=35.
- At PC=18, JMP target 17: oAddress=17. A JMP/NOP loop alternates 17 <-> 18 indefinitely with oDepth unchanged.
- Overflow: 8 nested CALLs target 40 fill the stack (oDepth=8). A 9th CALL gives oOverflow=1, oHalted=1, and oAddress stays 40 for 5+ cycles. Reset low clears to 0.
- Underflow: RET right after reset gives oUnderflow=1, oHalted=1, oAddress=0. Drive Reset low asynchronously mid-cycle: all outputs reach reset values before the next clock edge.
